// File: rtl/mips32_pkg.sv
// ---------------------------------------------------------------------------
// mips32_pkg
// Shared definitions for the MIPS32 front end: opcode and instruction-type
// codes, instruction-memory address width, default fetch-queue depth and the
// fetch-queue entry layout.
// No ports (package).
// ---------------------------------------------------------------------------
package mips32_pkg;

  localparam int IMEM_AW  = 10;  // instruction memory is 1024 words
  localparam int FQ_DEPTH = 4;   // default fetch-queue depth

  typedef enum logic [5:0] {
    OP_ADD   = 6'b000000,
    OP_SUB   = 6'b000001,
    OP_AND   = 6'b000010,
    OP_OR    = 6'b000011,
    OP_SLT   = 6'b000100,
    OP_MUL   = 6'b000101,
    OP_LW    = 6'b001000,
    OP_SW    = 6'b001001,
    OP_ADDI  = 6'b001010,
    OP_SUBI  = 6'b001011,
    OP_SLTI  = 6'b001100,
    OP_BNEQZ = 6'b001101,
    OP_BEQZ  = 6'b001110,
    OP_HLT   = 6'b111111
  } opcode_e;

  typedef enum logic [2:0] {
    RR_ALU = 3'd0,
    RM_ALU = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    BRANCH = 3'd4,
    HALT   = 3'd5
  } itype_e;

  // One buffered instruction: the word itself and its fetch address + 1.
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } fq_entry_t;

  // Classify an instruction word by its opcode field (bits 31:26).
  function automatic itype_e decode_type(input logic [31:0] ir);
    itype_e t;
    case (ir[31:26])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: t = RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     t = RM_ALU;
      OP_LW:                                         t = LOAD;
      OP_SW:                                         t = STORE;
      OP_BNEQZ, OP_BEQZ:                             t = BRANCH;
      default:                                       t = HALT;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mips32_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// mips32_fetch_queue_if
// Bundles the fetch queue's instruction-memory bus, redirect/halt controls
// and the instruction handshake toward the ID stage.
//   master : the fetch queue side (drives imem_rd_en/addr, inst_*)
//   slave  : the environment side (memory, branch unit, ID stage)
// ---------------------------------------------------------------------------
interface mips32_fetch_queue_if;
  import mips32_pkg::*;

  logic               imem_rd_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               halt;
  logic               inst_valid;
  logic [31:0]        inst_ir;
  logic [31:0]        inst_npc;
  logic               inst_ready;

  modport master (
    output imem_rd_en, imem_addr, inst_valid, inst_ir, inst_npc,
    input  imem_rdata, redirect_valid, redirect_pc, halt, inst_ready
  );

  modport slave (
    input  imem_rd_en, imem_addr, inst_valid, inst_ir, inst_npc,
    output imem_rdata, redirect_valid, redirect_pc, halt, inst_ready
  );

endinterface

// File: rtl/mips32_sync_fifo.sv
// ---------------------------------------------------------------------------
// mips32_sync_fifo
// Single-clock FIFO with a registered head entry, so the head output never
// has a combinational path from the write data.
//   clk1, rst_n : clock, asynchronous active-low reset
//   flush       : empty the FIFO (wins over push/pop)
//   push, wdata : write an entry at the tail
//   pop         : drop the head entry (ignored when empty)
//   head        : registered head entry
//   count       : number of stored entries (0..DEPTH)
//   full, empty : occupancy flags
// ---------------------------------------------------------------------------
module mips32_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] head_reg, head_next;
  logic             do_pop;
  logic [CW-1:0]    kept;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    head_next   = head_reg;
    do_pop      = pop && (count_reg != '0);
    kept        = count_reg - CW'(do_pop);  // old entries surviving this edge
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_pop) rd_ptr_next = rd_ptr_reg + AW'(1);
      if (push)   wr_ptr_next = wr_ptr_reg + AW'(1);
      count_next = kept + CW'(push);
      // Head is reloaded from the array when an older entry remains,
      // otherwise it is captured straight from the incoming write.
      if (kept != '0)  head_next = mem[rd_ptr_next];
      else if (push)   head_next = wdata;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

  // Storage array carries no reset so it can map onto RAM.
  always_ff @(posedge clk1) begin
    if (push && !flush) mem[wr_ptr_reg] <= wdata;
  end

  assign head  = head_reg;
  assign count = count_reg;
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/mips32_fetch_queue.sv
// ---------------------------------------------------------------------------
// mips32_fetch_queue
// Instruction fetch front end: issues sequential word reads to a 1-cycle
// instruction memory, buffers responses in a small FIFO and hands them to
// the ID stage with a valid/ready handshake. Handles branch redirects
// (flush + refetch) and halt (stop issuing, drain what is buffered).
//   clk1, rst_n : clock, asynchronous active-low reset
//   bus         : mips32_fetch_queue_if.master
//                 imem_rd_en/imem_addr/imem_rdata - instruction memory
//                 redirect_valid/redirect_pc      - taken branch
//                 halt                            - stop fetching
//                 inst_valid/inst_ir/inst_npc/inst_ready - ID handshake
// ---------------------------------------------------------------------------
module mips32_fetch_queue
  import mips32_pkg::*;
#(
  parameter int          DEPTH    = FQ_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                  clk1,
  input logic                  rst_n,
  mips32_fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   resp_npc_reg, resp_npc_next;  // npc of the read in flight
  logic          inflight_reg, inflight_next;
  logic          drop_pending_reg, drop_pending_next;

  logic          issue, push, pop, flush;
  logic [CW-1:0] fifo_count, occupancy;
  logic          fifo_full, fifo_empty;
  fq_entry_t     push_entry, head_entry;

  always_comb begin
    // Credit: buffered entries plus the response still on its way must
    // leave room, so a push can never land on a full FIFO.
    occupancy = fifo_count + CW'(inflight_reg);
    // Gated by rst_n so the strobe is low for the whole reset interval.
    issue = rst_n && !bus.halt && !bus.redirect_valid && !drop_pending_reg &&
            (occupancy < CW'(DEPTH));
    flush = bus.redirect_valid;
    // The response arriving on a redirect edge belongs to the old path and
    // is discarded by the flush.
    push  = inflight_reg && !drop_pending_reg && !bus.redirect_valid;
    pop   = !fifo_empty && bus.inst_ready;
    push_entry.ir  = bus.imem_rdata;
    push_entry.npc = resp_npc_reg;
  end

  always_comb begin
    fetch_pc_next     = fetch_pc_reg;
    resp_npc_next     = resp_npc_reg;
    inflight_next     = issue;
    // Marks a read strobed in the same cycle as a redirect; issue is held
    // low during redirects, so in practice this only clears the flag.
    drop_pending_next = bus.redirect_valid && issue;
    if (bus.redirect_valid) begin
      fetch_pc_next = bus.redirect_pc;
    end else if (issue) begin
      fetch_pc_next = fetch_pc_reg + 32'd1;  // wraps modulo 2^32
      resp_npc_next = fetch_pc_reg + 32'd1;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg     <= RESET_PC;
      resp_npc_reg     <= '0;
      inflight_reg     <= 1'b0;
      drop_pending_reg <= 1'b0;
    end else begin
      fetch_pc_reg     <= fetch_pc_next;
      resp_npc_reg     <= resp_npc_next;
      inflight_reg     <= inflight_next;
      drop_pending_reg <= drop_pending_next;
    end
  end

  mips32_sync_fifo #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk1  (clk1),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .head  (head_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.imem_rd_en = issue;
  assign bus.imem_addr  = fetch_pc_reg[IMEM_AW-1:0];
  assign bus.inst_valid = !fifo_empty;
  assign bus.inst_ir    = head_entry.ir;
  assign bus.inst_npc   = head_entry.npc;

  a_no_overflow: assert property (@(posedge clk1) disable iff (!rst_n)
                                  !(push && fifo_full));

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_mips32_fetch_queue
// Random and directed stimulus against a queue-based reference model of the
// fetch queue. A second instance with RESET_PC=1022 runs free to exercise
// the address wrap.
// ---------------------------------------------------------------------------
module tb_mips32_fetch_queue;
  import mips32_pkg::*;

  localparam int TB_DEPTH = 4;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } ent_t;

  logic clk1  = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk1 = ~clk1;

  mips32_fetch_queue_if bus ();
  mips32_fetch_queue_if wbus ();

  mips32_fetch_queue #(.DEPTH(TB_DEPTH), .RESET_PC(32'd0)) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mips32_fetch_queue #(.DEPTH(TB_DEPTH), .RESET_PC(32'd1022)) dut_wrap (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (wbus)
  );

  logic [31:0] mem [1024];

  int errors = 0;
  int checks = 0;

  // reference model state
  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_inflight;
  logic [31:0] m_iaddr;
  int          w_cyc;
  logic [31:0] w_npc;
  int          n_reads, n_xfers;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic step();
    bit          exp_rd, exp_valid, pop, rd_now, wrd;
    logic [9:0]  rd_addr, wa;
    ent_t        e;
    #1;
    exp_valid = (mq.size() != 0);
    exp_rd    = !bus.halt && !bus.redirect_valid &&
                ((mq.size() + int'(m_inflight)) < TB_DEPTH);
    check_eq("rd_en", {31'd0, bus.imem_rd_en}, {31'd0, exp_rd});
    if (exp_rd) check_eq("imem_addr", {22'd0, bus.imem_addr}, m_pc & 32'h3ff);
    check_eq("inst_valid", {31'd0, bus.inst_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      e = mq[0];
      check_eq("inst_ir", bus.inst_ir, e.ir);
      check_eq("inst_npc", bus.inst_npc, e.npc);
    end
    pop = exp_valid && bus.inst_ready;
    if (bus.inst_valid && bus.inst_ready) begin
      n_xfers++;
      $display("xfer ir=%h npc=%h", bus.inst_ir, bus.inst_npc);
    end
    if (bus.imem_rd_en) n_reads++;
    rd_now  = bus.imem_rd_en;
    rd_addr = bus.imem_addr;

    // free-running wrap instance: one read and (from cycle 2) one delivery per cycle
    check_eq("wrap_rd_en", {31'd0, wbus.imem_rd_en}, 32'd1);
    check_eq("wrap_addr", {22'd0, wbus.imem_addr}, (1022 + w_cyc) % 1024);
    check_eq("wrap_valid", {31'd0, wbus.inst_valid}, {31'd0, (w_cyc >= 2)});
    if (w_cyc >= 2) begin
      check_eq("wrap_ir", wbus.inst_ir, mem[(w_npc - 32'd1) & 32'h3ff]);
      check_eq("wrap_npc", wbus.inst_npc, w_npc);
      if (w_cyc == 4) check_eq("wrap_npc_third", wbus.inst_npc, 32'd1025);
      w_npc = w_npc + 32'd1;
    end
    wrd = wbus.imem_rd_en;
    wa  = wbus.imem_addr;

    @(posedge clk1);
    if (bus.redirect_valid) begin
      mq.delete();
      m_pc       = bus.redirect_pc;
      m_inflight = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_inflight) mq.push_back('{mem[m_iaddr[9:0]], m_iaddr + 32'd1});
      if (exp_rd) begin
        m_inflight = 1'b1;
        m_iaddr    = m_pc;
        m_pc       = m_pc + 32'd1;
      end else begin
        m_inflight = 1'b0;
      end
    end
    w_cyc++;
    #1;
    if (rd_now) bus.imem_rdata = mem[rd_addr];
    if (wrd)    wbus.imem_rdata = mem[wa];
    @(negedge clk1);
  endtask

  // Called just after a negedge; asserts reset between edges, checks the
  // outputs drop immediately, then releases on a later negedge.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_rd_en", {31'd0, bus.imem_rd_en}, 32'd0);
    check_eq("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check_eq("rst_ir", bus.inst_ir, 32'd0);
    check_eq("rst_npc", bus.inst_npc, 32'd0);
    check_eq("rst_wrap_valid", {31'd0, wbus.inst_valid}, 32'd0);
    mq.delete();
    m_pc       = 32'd0;
    m_inflight = 1'b0;
    w_cyc      = 0;
    w_npc      = 32'd1023;
    @(negedge clk1);
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    bus.halt = 1'b0;  bus.redirect_valid = 1'b0;  bus.redirect_pc = 32'd0;
    bus.inst_ready = 1'b1;  bus.imem_rdata = 32'd0;
    wbus.halt = 1'b0; wbus.redirect_valid = 1'b0; wbus.redirect_pc = 32'd0;
    wbus.inst_ready = 1'b1; wbus.imem_rdata = 32'd0;

    // reset release, free-running: A,B,C,D from cycle 2
    @(negedge clk1);
    pulse_reset();
    n_xfers = 0;
    repeat (6) step();
    check_eq("startup_xfers", n_xfers, 32'd4);

    // stall from reset: exactly DEPTH reads, then release in order
    pulse_reset();
    bus.inst_ready = 1'b0;
    n_reads = 0;
    repeat (10) step();
    check_eq("stall_reads", n_reads, TB_DEPTH);
    check_eq("stall_rd_en", {31'd0, bus.imem_rd_en}, 32'd0);
    bus.inst_ready = 1'b1;
    n_xfers = 0;
    repeat (6) step();
    check_eq("stall_release_xfers", n_xfers, 32'd6);

    // redirect with 3 buffered + 1 in flight
    bus.inst_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mq.size() == 3 && m_inflight) break;
      step();
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    step();
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b1;
    check_eq("redir_empty", {31'd0, bus.inst_valid}, 32'd0);
    step();
    step();
    check_eq("redir_ir", bus.inst_ir, mem[10'h40]);
    check_eq("redir_npc", bus.inst_npc, 32'h41);
    repeat (3) step();

    // halt with 2 buffered + 1 in flight
    bus.inst_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mq.size() == 2 && m_inflight) break;
      step();
    end
    bus.halt       = 1'b1;
    bus.inst_ready = 1'b1;
    n_xfers = 0;
    n_reads = 0;
    repeat (6) step();
    check_eq("halt_xfers", n_xfers, 32'd3);
    check_eq("halt_reads", n_reads, 32'd0);
    check_eq("halt_valid", {31'd0, bus.inst_valid}, 32'd0);
    bus.halt = 1'b0;
    repeat (5) step();

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      bus.inst_ready     = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) bus.halt = !bus.halt;
      bus.redirect_valid = ($urandom_range(0, 24) == 0);
      bus.redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE
                                                       : $urandom_range(0, 2047);
      step();
    end
    bus.halt = 1'b0;
    bus.redirect_valid = 1'b0;

    // asynchronous reset with a full queue
    bus.inst_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mq.size() == TB_DEPTH) break;
      step();
    end
    check_eq("full_before_rst", {31'd0, bus.inst_valid}, 32'd1);
    pulse_reset();
    bus.inst_ready = 1'b1;
    step();
    step();
    check_eq("post_rst_ir", bus.inst_ir, mem[0]);
    check_eq("post_rst_npc", bus.inst_npc, 32'd1);
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips32_fetch_queue.md
MIPS32_FETCH_QUEUE -- requirements
Module: mips32_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, sets the number of instruction-buffer entries; legal values are powers of two from 2 to 16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, is the first word address fetched after reset.
REQ-003 clk1  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 imem_rd_en  output  1  instruction-memory read strobe.
REQ-006 imem_addr  output  10  word address, equal to fetch_pc[9:0].
REQ-007 imem_rdata  input  32  read data, valid exactly one cycle after imem_rd_en.
REQ-008 redirect_valid  input  1  branch taken; flush the queue and refetch.
REQ-009 redirect_pc  input  32  branch target word address.
REQ-010 halt  input  1  HLT decoded downstream; stop issuing fetches.
REQ-011 inst_valid  output  1  queue head holds an instruction.
REQ-012 inst_ir  output  32  head instruction word.
REQ-013 inst_npc  output  32  head fetch address + 1.
REQ-014 inst_ready  input  1  the ID stage accepts the head this cycle.

Function
REQ-015 The block holds a 32-bit fetch_pc; word-addressed, incremented by 1 per issued read; the 32-bit value wraps modulo 2^32, imem_addr wraps 1023->0.
REQ-016 imem_rd_en is asserted iff not halt, not redirect_valid, not drop_pending, and (count + inflight) < DEPTH, where inflight is 1 when a read was issued in the previous cycle.
REQ-017 An issued read pushes {imem_rdata, addr+1} into the tail on the following edge, unless that response is marked dropped.
REQ-018 A transfer occurs when inst_valid and inst_ready are both 1; the head is popped on that edge.
REQ-019 A push and a pop on the same edge leave count unchanged, and the FIFO order is preserved.
REQ-020 The credit rule of REQ-016 guarantees no push while full; an overflow is a design error and is flagged by an assertion.
REQ-021 inst_valid = (count != 0); inst_ir and inst_npc come from a registered head entry, with no combinational path from imem_rdata.
REQ-022 On redirect_valid: the queue is emptied (count=0, pointers reset), fetch_pc <= redirect_pc, any in-flight response is marked dropped, and no read is issued that cycle.
REQ-023 redirect_valid has priority over push, pop and halt on the same edge; a same-cycle pop is still counted as transferred before the flush.
REQ-024 Fetch restarts at redirect_pc on the cycle after the redirect; the first redirected instruction is inst_valid 2 cycles after the redirect edge.
REQ-025 While halt=1: no new reads; an in-flight response is still pushed; the queue drains normally; fetch_pc holds.
REQ-026 Lowering halt resumes fetch at the held fetch_pc.
REQ-027 Latency from reset release: the read is issued at the first edge, and inst_valid=1 with inst_ir=Mem[RESET_PC] after the second edge.
REQ-028 Sustained throughput is one instruction per cycle when inst_ready=1 continuously and DEPTH>=2.

Reset
REQ-029 While rst_n=0, the block forces: fetch_pc=RESET_PC, count=0, pointers=0, inflight=0, drop_pending=0, imem_rd_en=0, inst_valid=0, inst_ir=0, inst_npc=0.
REQ-030 A reset asserted mid-operation discards all entries and in-flight responses immediately; buffer RAM contents need not be cleared.
REQ-031 The first fetch follows the first clk1 edge after rst_n deasserts; no response arriving from before the reset is ever pushed.

Structure
REQ-032 Package mips32_pkg holds: the opcode constants (ADD..BEQZ, HLT), the instruction-type codes (RR_ALU..HALT), IMEM_AW=10, and the default fetch-queue DEPTH.
REQ-033 One sub-module, mips32_sync_fifo (parameterised width/depth, push/pop/flush, count output), implements the buffer; the control logic (fetch_pc, credit, drop) lives in mips32_fetch_queue.

Verification
REQ-034 Reset release with Mem[0..3]=A,B,C,D and inst_ready=1 -> inst_ir = A,B,C,D on consecutive cycles from cycle 2; inst_npc = 1,2,3,4.
REQ-035 inst_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 reads issued, count=4, imem_rd_en=0 thereafter; on release -> A..D in order, with no loss and no duplicates.
REQ-036 redirect_valid=1 with redirect_pc=0x40 while the queue holds 3 entries and one read is in flight -> the queue empties, the stale response is dropped, and the next inst_ir = Mem[0x40] with inst_npc = 0x41.
REQ-037 halt=1 with 2 entries and 1 in flight -> 3 instructions delivered, then inst_valid=0 with no reads; halt=0 -> fetch resumes at the next sequential address.
REQ-038 RESET_PC=1022, free-running -> imem_addr sequence 1022, 1023, 0, 1, and inst_npc of the third instruction = 1025.
REQ-039 rst_n pulsed low mid-stream with the queue full -> outputs are zero immediately (asynchronous), and after release the first inst_ir = Mem[RESET_PC].
